// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_REG_W       = 4;
  localparam int DEF_TIMEOUT_CYC = 16;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts ACCESS cycles spent waiting for mem_ack; tc marks the last allowed cycle.
// Latency: tc is combinational from the count register.
// Backpressure: none; clear has priority over enable.
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step once per waiting cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory access, fault detection, MEM/WB register.
// Latency: 1 cycle for non-memory ops; 1 + ACCESS cycles for loads/stores.
// Backpressure: stall_out holds upstream while a request is outstanding.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regw_in,
  input  logic              memw_in,
  input  logic              memr_in,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [REG_W-1:0]  rd_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_regw,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              fault
);

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                regw_lat_q, regw_lat_d;
  logic [REG_W-1:0]    rd_lat_q, rd_lat_d;
  logic                wb_regw_q, wb_regw_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [REG_W-1:0]    wb_rd_q, wb_rd_d;
  logic                fault_q, fault_d;
  logic                stall_c;
  logic                cnt_clr, cnt_en, cnt_tc;
  logic                access, illegal;

  assign access  = memr_in | memw_in;
  assign illegal = (memr_in & memw_in) | (access & ~is_word_aligned(alu_result[1:0]));

  mem_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  // Next-state, bus latch and MEM/WB update; WB only moves when not stalling.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    regw_lat_d = regw_lat_q;
    rd_lat_d   = rd_lat_q;
    wb_regw_d  = wb_regw_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    fault_d    = fault_q;
    stall_c    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!access) begin
          wb_regw_d = regw_in;
          wb_data_d = alu_result;
          wb_rd_d   = rd_in;
        end else if (illegal) begin
          // Faulting instruction retires as a bubble without touching memory.
          wb_regw_d = 1'b0;
          fault_d   = 1'b1;
        end else begin
          stall_c    = 1'b1;
          mem_req_d  = 1'b1;
          we_d       = memw_in;
          addr_d     = alu_result;
          wdata_d    = store_data;
          regw_lat_d = regw_in;
          rd_lat_d   = rd_in;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          // Ack beats a coincident timeout.
          wb_regw_d = regw_lat_q;
          wb_rd_d   = rd_lat_q;
          wb_data_d = we_q ? addr_q : mem_rdata;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (cnt_tc) begin
          wb_regw_d = 1'b0;
          fault_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_en  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage registers; reset drops the request and clears WB immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      regw_lat_q <= 1'b0;
      rd_lat_q   <= '0;
      wb_regw_q  <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      regw_lat_q <= regw_lat_d;
      rd_lat_q   <= rd_lat_d;
      wb_regw_q  <= wb_regw_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      fault_q    <= fault_d;
    end
  end

  // Stall is combinational but forced low while reset is held.
  assign stall_out = stall_c & ~reset;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_regw   = wb_regw_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        regw_in, memw_in, memr_in;
  logic [31:0] store_data, alu_result, mem_rdata;
  logic [3:0]  rd_in;
  logic        mem_ack;
  logic        stall_out, mem_req, mem_we, wb_regw, fault;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  wb_rd;

  typedef struct {
    logic        regw;
    logic [31:0] data;
    logic [3:0]  rd;
    bit          full;
  } wb_exp_t;

  wb_exp_t sb[$];
  int tests = 0;
  int fails = 0;

  mem_access_stage #(.DATA_W(32), .REG_W(4), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .regw_in    (regw_in),
    .memw_in    (memw_in),
    .memr_in    (memr_in),
    .store_data (store_data),
    .alu_result (alu_result),
    .rd_in      (rd_in),
    .stall_out  (stall_out),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .wb_regw    (wb_regw),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wb(input logic regw, input logic [31:0] data, input logic [3:0] rd, input bit full);
    wb_exp_t e;
    e.regw = regw; e.data = data; e.rd = rd; e.full = full;
    sb.push_back(e);
  endtask

  task automatic pop_wb(input string tag);
    wb_exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_wb_regw"}, {31'd0, wb_regw}, {31'd0, e.regw});
    if (e.full) begin
      chk({tag, "_wb_data"}, wb_data, e.data);
      chk({tag, "_wb_rd"}, {28'd0, wb_rd}, {28'd0, e.rd});
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic rg,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] rd);
    memr_in = r; memw_in = w; regw_in = rg;
    alu_result = addr; store_data = wd; rd_in = rd;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Issue one memory op; garbage inputs during ACCESS must be ignored.
  task automatic mem_op(input logic r, input logic w, input logic rg,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] rd,
                        input bit give_ack, input int waits, input logic [31:0] rdata,
                        output int stall_cyc, output int req_cyc, output bit bus_ok);
    int n;
    n = give_ack ? waits + 1 : TO;
    stall_cyc = 0; req_cyc = 0; bus_ok = 1'b1;
    @(negedge clk);
    drive(r, w, rg, addr, wd, rd);
    #1;
    if (stall_out) stall_cyc++;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (mem_req) req_cyc++;
      if (!mem_req || mem_addr !== addr || mem_wdata !== wd || mem_we !== w) bus_ok = 1'b0;
      @(negedge clk);
      drive(1'b1, 1'b1, ~rg, 32'hFFFF_FFF3, ~wd, ~rd);
      mem_ack   = give_ack && (i == waits);
      mem_rdata = mem_ack ? rdata : 32'h0BAD_0BAD;
      #1;
      if (stall_out) stall_cyc++;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    nop();
  endtask

  int  st, rq;
  bit  ok;

  initial begin
    reset = 1'b1;
    nop();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    #12;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_wb_regw", {31'd0, wb_regw}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ALU op: one-cycle pass-through, no stall.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 4'd5);
    push_wb(1'b1, 32'h1234, 4'd5, 1'b1);
    #1;
    chk("alu_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    pop_wb("alu");
    chk("alu_mem_req", {31'd0, mem_req}, 32'd0);

    // Zero-wait load.
    push_wb(1'b1, 32'hDEAD_BEEF, 4'd3, 1'b1);
    mem_op(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 4'd3, 1'b1, 0, 32'hDEAD_BEEF, st, rq, ok);
    chk("ld_stall_cyc", st, 32'd1);
    chk("ld_req_cyc", rq, 32'd1);
    chk("ld_bus", {31'd0, ok}, 32'd1);
    chk("ld_req_drop", {31'd0, mem_req}, 32'd0);
    pop_wb("ld");

    // Store with three waits; the ack lands on the timeout cycle and must win.
    push_wb(1'b0, 32'h80, 4'd9, 1'b1);
    mem_op(1'b0, 1'b1, 1'b0, 32'h80, 32'hA5A5_A5A5, 4'd9, 1'b1, 3, 32'h0, st, rq, ok);
    chk("st_stall_cyc", st, 32'd4);
    chk("st_req_cyc", rq, 32'd4);
    chk("st_bus", {31'd0, ok}, 32'd1);
    chk("st_no_fault", {31'd0, fault}, 32'd0);
    pop_wb("st");

    // Back-to-back load with two waits.
    push_wb(1'b1, 32'h1357_9BDF, 4'd2, 1'b1);
    mem_op(1'b1, 1'b0, 1'b1, 32'h104, 32'h0, 4'd2, 1'b1, 2, 32'h1357_9BDF, st, rq, ok);
    chk("ld2_stall_cyc", st, 32'd3);
    chk("ld2_req_cyc", rq, 32'd3);
    chk("ld2_bus", {31'd0, ok}, 32'd1);
    pop_wb("ld2");

    // Timeout: no ack at all.
    push_wb(1'b0, 32'h0, 4'd0, 1'b0);
    mem_op(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 4'd6, 1'b0, 0, 32'h0, st, rq, ok);
    chk("to_stall_cyc", st, 32'd4);
    chk("to_req_cyc", rq, 32'd4);
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_fault", {31'd0, fault}, 32'd1);
    pop_wb("to");

    // Reset in the middle of an access.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 4'd4);
    @(posedge clk); #1;
    chk("mid_req_up", {31'd0, mem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_out}, 32'd0);
    chk("mid_rst_wb_regw", {31'd0, wb_regw}, 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_wb_rd", {28'd0, wb_rd}, 32'd0);
    chk("mid_rst_fault", {31'd0, fault}, 32'd0);

    // Ack while IDLE is ignored; the ALU op flows through.
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 4'd7);
    mem_ack = 1'b1;
    mem_rdata = 32'h99;
    push_wb(1'b1, 32'h55, 4'd7, 1'b1);
    #1;
    chk("idle_ack_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
    chk("idle_ack_fault", {31'd0, fault}, 32'd0);
    pop_wb("idle_ack");

    // Load and store together at an aligned address is illegal.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h10, 32'h1, 4'd8);
    push_wb(1'b0, 32'h0, 4'd0, 1'b0);
    #1;
    chk("ill_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    chk("ill_req", {31'd0, mem_req}, 32'd0);
    chk("ill_fault", {31'd0, fault}, 32'd1);
    pop_wb("ill");

    // Fresh reset, then a misaligned load.
    @(negedge clk);
    reset = 1'b1;
    nop();
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h41, 32'h0, 4'd1);
    push_wb(1'b0, 32'h0, 4'd0, 1'b0);
    #1;
    chk("mis_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    pop_wb("mis");

    // Fault stays sticky across later ALU ops.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 32'h1000 + 32'(k), 32'h0, 4'(10 + k));
      push_wb(1'b1, 32'h1000 + 32'(k), 4'(10 + k), 1'b1);
      @(posedge clk); #1;
      pop_wb("post_alu");
      chk("post_fault", {31'd0, fault}, 32'd1);
    end

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
